// File: rtl/ef_smsdac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ef_smsdac_pkg
// Description : Shared types and constants for the SMS DAC dither channels.
// Revision    : 1.0 - initial release
// ============================================================================
package ef_smsdac_pkg;

    typedef enum logic [0:0] {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } dith_state_t;

    // x^10 + x^3 + 1 feedback for the legacy 10-bit generator
    localparam logic [9:0] c_taps_w10 = 10'b0000001001;

    localparam int c_wcnt_w = 8;

endpackage
`default_nettype wire

// File: rtl/ef_smsdac_lfsr_jump.sv
`default_nettype none
// ============================================================================
// Module      : ef_smsdac_lfsr_jump
// Description : Combinational STEP-fold unrolling of a right-shifting LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module ef_smsdac_lfsr_jump #(
    parameter int               WIDTH = 10,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(10'b0000001001),
    parameter int               STEP  = 5
) (
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_jump
);

    logic [WIDTH-1:0] w_stage [0:STEP];

    assign w_stage[0] = q;

    for (genvar gi = 0; gi < STEP; gi++) begin : g_step
        assign w_stage[gi+1] = {^(w_stage[gi] & TAPS), w_stage[gi][WIDTH-1:1]};
    end

    assign q_jump = w_stage[STEP];

endmodule
`default_nettype wire

// File: rtl/ef_smsdac_lfsr_dith.sv
`default_nettype none
// ============================================================================
// Module      : ef_smsdac_lfsr_dith
// Description : Parametrised LFSR dither source with seed load, warm-up
//               window and all-zero lock-up recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module ef_smsdac_lfsr_dith
    import ef_smsdac_pkg::*;
#(
    parameter int               WIDTH = 10,
    parameter int               NOUT  = 7,
    parameter int               STEP  = 5,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(c_taps_w10),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int               WARM  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_dith,
    input  logic             seed_ld,
    input  logic [WIDTH-1:0] seed_val,
    output logic [NOUT-1:0]  r,
    output logic             dith_vld,
    output logic             lock_err
);

    localparam dith_state_t c_st_init = (WARM > 0) ? ST_WARM : ST_RUN;
    localparam logic [c_wcnt_w-1:0] c_warm_last = c_wcnt_w'((WARM > 0) ? WARM - 1 : 0);

    logic [WIDTH-1:0]    r_q;
    logic [c_wcnt_w-1:0] r_wcnt;
    logic                r_lock_err;
    dith_state_t         r_state;
    dith_state_t         w_state_nxt;
    logic [WIDTH-1:0]    w_q_jump;
    logic                w_lock;
    logic                w_warm_done;

    ef_smsdac_lfsr_jump #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .STEP  (STEP)
    ) u_jump (
        .q      (r_q),
        .q_jump (w_q_jump)
    );

    assign w_lock      = (r_q == '0);
    assign w_warm_done = (r_state == ST_WARM) && (r_wcnt == c_warm_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_init;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lock-up recovery cycles consume the enable, so warm-up does not progress.
    always_comb begin
        w_state_nxt = r_state;
        if (seed_ld) begin
            w_state_nxt = c_st_init;
        end else if (!w_lock && en_dith && w_warm_done) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_comb begin
        dith_vld = (r_state == ST_RUN);
        r        = dith_vld ? r_q[WIDTH-1 -: NOUT] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q        <= SEED;
            r_wcnt     <= '0;
            r_lock_err <= 1'b0;
        end else if (seed_ld) begin
            r_q    <= (seed_val != '0) ? seed_val : SEED;
            r_wcnt <= '0;
        end else if (w_lock) begin
            r_q        <= SEED;
            r_lock_err <= 1'b1;
        end else if (en_dith) begin
            r_q <= w_q_jump;
            // Counter parks at WARM-1 so it cannot wrap
            if (r_state == ST_WARM && !w_warm_done) begin
                r_wcnt <= r_wcnt + c_wcnt_w'(1);
            end
        end
    end

    assign lock_err = r_lock_err;

endmodule
`default_nettype wire

// File: doc/ef_smsdac_lfsr_dith.md
Name: ef_smsdac_lfsr_dith

Overview:
- Parametrised LFSR dither source for the SMS DAC.
- Generalises the fixed 10-bit, 7-output, 5-step generator to configurable width, tap mask, output count and states-per-clock.
- Adds runtime seed load, an output warm-up window with a valid flag, and all-zero lock-up recovery.
- Drives the random selection bits of the mismatch-shaping element selector.

Parameters:
- WIDTH, 10, LFSR state width (4..32)
- NOUT, 7, number of tapped random outputs (1..WIDTH)
- STEP, 5, single LFSR steps taken per enabled clock (1..WIDTH)
- TAPS, 10'b0000001001, feedback mask; single-step feedback is the XOR of state bits selected by TAPS
- SEED, 1, default nonzero state used at reset, on zero seed load, and on lock-up recovery
- WARM, 0, enabled clocks after reset/seed load before outputs are declared valid (0..255)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en_dith  in  1  advance LFSR by STEP states this clock
- seed_ld  in  1  single-cycle request to load seed_val
- seed_val  in  WIDTH  seed value; zero means use SEED
- r  out  NOUT  random bits = q[WIDTH-1 -: NOUT] when dith_vld=1, else all zero
- dith_vld  out  1  outputs valid (state RUN)
- lock_err  out  1  sticky flag: all-zero state was detected and recovered

Behaviour:
- Single step: fb = ^(q & TAPS); q_next = {fb, q[WIDTH-1:1]}.
- Enabled clock applies the single step STEP times, combinationally unrolled, in one cycle.
- Defaults reproduce the existing generator exactly: q[9:5] <= q[4:0]^q[7:3], q[4:0] <= q[9:5].
- r and dith_vld are direct decodes of registered state; there is no extra output latency.
- Reset (rst=1 at clk edge) sets:
  - q=SEED
  - state=WARM if WARM>0, else RUN
  - wcnt=0
  - lock_err=0
  - Outputs therefore read r=0 (when WARM>0), dith_vld=(WARM==0), lock_err=0.
- rst has priority over everything.
- FSM states: WARM, RUN.
  - WARM: each en_dith clock advances q and increments wcnt. When wcnt==WARM-1 with en_dith=1, go to RUN. dith_vld=0, r=0.
  - RUN: each en_dith clock advances q. dith_vld=1.
  - en_dith=0 in either state: q, wcnt and state hold.
- Seed load (any state):
  - q <= (seed_val!=0) ? seed_val : SEED.
  - wcnt <= 0.
  - state <= WARM (RUN if WARM==0).
  - The loaded value is visible on the next cycle.
- Lock-up: if q==0 at a clock edge with no seed_ld, q <= SEED and lock_err <= 1. Recovery occurs regardless of en_dith and leaves state/wcnt unchanged.
- Priority for simultaneous events: rst > seed_ld > lock-up recovery > en_dith advance.
  - seed_ld together with en_dith: load only, no advance that cycle.
- lock_err clears only on rst.
- wcnt width is 8 bits; it never wraps because it stops at WARM-1.
- Period: 2^WIDTH-1 single steps for a primitive TAPS. With gcd(STEP, 2^WIDTH-1)=1 the per-clock sequence has the same period (1023 clocks at defaults).

Decomposition:
- Shared package ef_smsdac_pkg holds:
  - FSM state typedef (WARM, RUN)
  - default tap mask constant for WIDTH=10
  - wcnt width constant
- Sub-module ef_smsdac_lfsr_jump: purely combinational, parameters WIDTH/TAPS/STEP, input q, output q advanced STEP steps. Reused by other dither channels.

Test Plan:
- Defaults, reset, then en_dith=1 for 2 clocks:
  - after reset: q=0x001, r=0x00, dith_vld=1
  - clk1: q=0x020, r=0x04
  - clk2: q=0x081, r=0x10
- Defaults, en_dith=1 continuously from q=0x001:
  - q first returns to 0x001 at clock 1023, not before
  - all 1023 visited states distinct and nonzero
- WARM=3, reset, en_dith toggling 1,0,1,1:
  - dith_vld rises only after the 3rd enabled clock
  - r=0 while dith_vld=0
  - q still advances during WARM
- seed_ld=1, seed_val=0x155, en_dith=1 in the same cycle:
  - next cycle q=0x155 (no advance)
  - with WARM=3, dith_vld=0 and wcnt=0
  - seed_val=0 instead: q=0x001
- Force q=0 (backdoor), en_dith=0:
  - next cycle q=0x001, lock_err=1
  - lock_err stays 1 across further seed loads until rst
- rst asserted mid-RUN with seed_ld=1 and en_dith=1 on the same edge:
  - reset wins: q=SEED, lock_err=0, wcnt=0
